// File: rtl/mandelbrot_regs_pkg.sv
// Shared register map, response codes and FSM encodings for the Mandelbrot view
// register block and its AXI-Lite slave.
package mandelbrot_regs_pkg;

  localparam int REG_CTRL     = 0;
  localparam int REG_ZOOM_LO  = 1;
  localparam int REG_ZOOM_HI  = 2;
  localparam int REG_RE_LO    = 3;
  localparam int REG_RE_HI    = 4;
  localparam int REG_IM_LO    = 5;
  localparam int REG_IM_HI    = 6;
  localparam int REG_MAX_ITER = 7;
  localparam int REG_SCRATCH  = 8;

  // Read-only registers sit at the top of the map, counted back from NUM_REGS.
  localparam int OFS_STATUS    = 4;
  localparam int OFS_FRAME_CNT = 3;
  localparam int OFS_VERSION   = 2;
  localparam int OFS_ZERO      = 1;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_COMMIT = 1;

  localparam logic [1:0]  AXI_OK  = 2'b00;
  localparam logic [1:0]  AXI_ERR = 2'b10;
  localparam logic [31:0] VERSION = 32'h0002_0000;

  typedef enum logic [2:0] {WR_IDLE, WR_WDATA, WR_WADDR, WR_WRITE, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_DATA} rd_state_t;

endpackage

// File: rtl/axil_reg_slave.sv
// AXI-Lite slave front end: independent write/read FSMs, address decode and
// response generation; presents a simple indexed register port to its parent.
module axil_reg_slave
  import mandelbrot_regs_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 8,
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                  s_axi_lite_aclk,
  input  logic                  periph_resetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                  s_axi_lite_awvalid,
  output logic                  s_axi_lite_awready,
  input  logic [31:0]           s_axi_lite_wdata,
  input  logic [3:0]            s_axi_lite_wstrb,
  input  logic                  s_axi_lite_wvalid,
  output logic                  s_axi_lite_wready,
  output logic [1:0]            s_axi_lite_bresp,
  output logic                  s_axi_lite_bvalid,
  input  logic                  s_axi_lite_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic                  s_axi_lite_arvalid,
  output logic                  s_axi_lite_arready,
  output logic [31:0]           s_axi_lite_rdata,
  output logic [1:0]            s_axi_lite_rresp,
  output logic                  s_axi_lite_rvalid,
  input  logic                  s_axi_lite_rready,
  output logic                  wr_en,
  output logic [IDX_W-1:0]      wr_idx,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_strb,
  output logic [IDX_W-1:0]      rd_idx,
  input  logic [31:0]           rd_data
);

  wr_state_t wr_st, wr_nxt;
  rd_state_t rd_st, rd_nxt;
  logic [ADDR_WIDTH-1:0] aw_q, ar_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic wr_err, rd_err;

  function automatic logic addr_bad(logic [ADDR_WIDTH-1:0] a);
    return (a >> (2 + IDX_W)) != '0;
  endfunction

  assign wr_idx  = aw_q[2 +: IDX_W];
  assign rd_idx  = ar_q[2 +: IDX_W];
  assign wr_err  = addr_bad(aw_q) || (int'(wr_idx) >= NUM_REGS - OFS_STATUS);
  assign rd_err  = addr_bad(ar_q);
  assign wr_data = w_data_q;
  assign wr_strb = w_strb_q;

  always_comb begin
    wr_nxt             = wr_st;
    s_axi_lite_awready = 1'b0;
    s_axi_lite_wready  = 1'b0;
    s_axi_lite_bvalid  = 1'b0;
    wr_en              = 1'b0;
    case (wr_st)
      WR_IDLE: begin
        s_axi_lite_awready = 1'b1;
        s_axi_lite_wready  = 1'b1;
        if (s_axi_lite_awvalid && s_axi_lite_wvalid) wr_nxt = WR_WRITE;
        else if (s_axi_lite_awvalid)                 wr_nxt = WR_WDATA;
        else if (s_axi_lite_wvalid)                  wr_nxt = WR_WADDR;
      end
      WR_WDATA: begin
        s_axi_lite_wready = 1'b1;
        if (s_axi_lite_wvalid) wr_nxt = WR_WRITE;
      end
      WR_WADDR: begin
        s_axi_lite_awready = 1'b1;
        if (s_axi_lite_awvalid) wr_nxt = WR_WRITE;
      end
      WR_WRITE: begin
        wr_en  = !wr_err;
        wr_nxt = WR_RESP;
      end
      WR_RESP: begin
        s_axi_lite_bvalid = 1'b1;
        if (s_axi_lite_bready) wr_nxt = WR_IDLE;
      end
      default: wr_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      wr_st            <= WR_IDLE;
      aw_q             <= '0;
      w_data_q         <= '0;
      w_strb_q         <= '0;
      s_axi_lite_bresp <= AXI_OK;
    end else begin
      wr_st <= wr_nxt;
      if (s_axi_lite_awvalid && s_axi_lite_awready) aw_q <= s_axi_lite_awaddr;
      if (s_axi_lite_wvalid && s_axi_lite_wready) begin
        w_data_q <= s_axi_lite_wdata;
        w_strb_q <= s_axi_lite_wstrb;
      end
      if (wr_st == WR_WRITE) s_axi_lite_bresp <= wr_err ? AXI_ERR : AXI_OK;
    end
  end

  always_comb begin
    rd_nxt             = rd_st;
    s_axi_lite_arready = 1'b0;
    s_axi_lite_rvalid  = 1'b0;
    case (rd_st)
      RD_IDLE: begin
        s_axi_lite_arready = 1'b1;
        if (s_axi_lite_arvalid) rd_nxt = RD_FETCH;
      end
      RD_FETCH: rd_nxt = RD_DATA;
      RD_DATA: begin
        s_axi_lite_rvalid = 1'b1;
        if (s_axi_lite_rready) rd_nxt = RD_IDLE;
      end
      default: rd_nxt = RD_IDLE;
    endcase
  end

  // rdata/rresp only load in FETCH, so they stay put for the whole DATA phase.
  always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      rd_st            <= RD_IDLE;
      ar_q             <= '0;
      s_axi_lite_rdata <= '0;
      s_axi_lite_rresp <= AXI_OK;
    end else begin
      rd_st <= rd_nxt;
      if (s_axi_lite_arvalid && s_axi_lite_arready) ar_q <= s_axi_lite_araddr;
      if (rd_st == RD_FETCH) begin
        s_axi_lite_rdata <= rd_err ? 32'h0 : rd_data;
        s_axi_lite_rresp <= rd_err ? AXI_ERR : AXI_OK;
      end
    end
  end

endmodule

// File: rtl/mandelbrot_view_regs.sv
// Mandelbrot view parameter registers: shadow copies written over AXI-Lite,
// promoted to the active outputs only at a frame_start while a commit is pending.
module mandelbrot_view_regs
  import mandelbrot_regs_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WORD_LENGTH = 64,
  parameter int FRAC        = 60,
  parameter logic [63:0] RST_ZOOM = 64'd1024,
  parameter logic [15:0] RST_ITER = 16'd255,
  parameter logic [63:0] RST_IM   = 64'd0,
  parameter logic signed [63:0] RST_RE = -(64'sd3 <<< (FRAC - 2))
) (
  input  logic                   s_axi_lite_aclk,
  input  logic                   periph_resetn,
  input  logic [ADDR_WIDTH-1:0]  s_axi_lite_awaddr,
  input  logic                   s_axi_lite_awvalid,
  output logic                   s_axi_lite_awready,
  input  logic [31:0]            s_axi_lite_wdata,
  input  logic [3:0]             s_axi_lite_wstrb,
  input  logic                   s_axi_lite_wvalid,
  output logic                   s_axi_lite_wready,
  output logic [1:0]             s_axi_lite_bresp,
  output logic                   s_axi_lite_bvalid,
  input  logic                   s_axi_lite_bready,
  input  logic [ADDR_WIDTH-1:0]  s_axi_lite_araddr,
  input  logic                   s_axi_lite_arvalid,
  output logic                   s_axi_lite_arready,
  output logic [31:0]            s_axi_lite_rdata,
  output logic [1:0]             s_axi_lite_rresp,
  output logic                   s_axi_lite_rvalid,
  input  logic                   s_axi_lite_rready,
  input  logic                   frame_start,
  input  logic                   frame_done,
  output logic [WORD_LENGTH-1:0] zoom,
  output logic [WORD_LENGTH-1:0] re_center,
  output logic [WORD_LENGTH-1:0] im_center,
  output logic [15:0]            max_iter,
  output logic                   enable,
  output logic                   commit_ack
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int NUM_RW = NUM_REGS - OFS_STATUS;
  localparam int HW     = WORD_LENGTH - 32;
  localparam logic [31:0] HI_MASK = 32'hFFFF_FFFF >> (64 - WORD_LENGTH);

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [31:0]      wr_data, rd_data;
  logic [3:0]       wr_strb;
  logic [NUM_RW-1:0][31:0] rw_q, rw_nxt;
  logic             pending, commit_wr;
  logic [31:0]      frame_cnt;

  axil_reg_slave #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_slave (
    .s_axi_lite_aclk, .periph_resetn,
    .s_axi_lite_awaddr, .s_axi_lite_awvalid, .s_axi_lite_awready,
    .s_axi_lite_wdata, .s_axi_lite_wstrb, .s_axi_lite_wvalid, .s_axi_lite_wready,
    .s_axi_lite_bresp, .s_axi_lite_bvalid, .s_axi_lite_bready,
    .s_axi_lite_araddr, .s_axi_lite_arvalid, .s_axi_lite_arready,
    .s_axi_lite_rdata, .s_axi_lite_rresp, .s_axi_lite_rvalid, .s_axi_lite_rready,
    .wr_en, .wr_idx, .wr_data, .wr_strb, .rd_idx, .rd_data
  );

  function automatic logic [31:0] reg_mask(int i);
    case (i)
      REG_CTRL:                          return 32'h1;
      REG_ZOOM_HI, REG_RE_HI, REG_IM_HI: return HI_MASK;
      REG_MAX_ITER:                      return 32'h0000_FFFF;
      default:                           return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] rst_val(int i);
    case (i)
      REG_ZOOM_LO:  return RST_ZOOM[31:0];
      REG_ZOOM_HI:  return RST_ZOOM[63:32] & HI_MASK;
      REG_RE_LO:    return RST_RE[31:0];
      REG_RE_HI:    return RST_RE[63:32] & HI_MASK;
      REG_IM_LO:    return RST_IM[31:0];
      REG_IM_HI:    return RST_IM[63:32] & HI_MASK;
      REG_MAX_ITER: return {16'h0, RST_ITER};
      default:      return 32'h0;
    endcase
  endfunction

  // Next-state view of the shadow registers doubles as the read source so a
  // read in the same cycle as a write sees the new value.
  always_comb begin
    for (int i = 0; i < NUM_RW; i++) begin
      rw_nxt[i] = rw_q[i];
      if (wr_en && wr_idx == IDX_W'(i))
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) rw_nxt[i][8*b +: 8] = wr_data[8*b +: 8];
      rw_nxt[i] = rw_nxt[i] & reg_mask(i);
    end
  end

  assign commit_wr = wr_en && wr_idx == IDX_W'(REG_CTRL) && wr_strb[0] && wr_data[CTRL_COMMIT];

  always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= rst_val(i);
      pending    <= 1'b0;
      commit_ack <= 1'b0;
      frame_cnt  <= '0;
      zoom       <= RST_ZOOM[WORD_LENGTH-1:0];
      re_center  <= RST_RE[WORD_LENGTH-1:0];
      im_center  <= RST_IM[WORD_LENGTH-1:0];
      max_iter   <= RST_ITER;
      enable     <= 1'b0;
    end else begin
      rw_q       <= rw_nxt;
      commit_ack <= frame_start && pending;
      if (frame_done) frame_cnt <= frame_cnt + 32'd1;
      if (frame_start && pending) begin
        pending   <= 1'b0;
        zoom      <= {rw_q[REG_ZOOM_HI][HW-1:0], rw_q[REG_ZOOM_LO]};
        re_center <= {rw_q[REG_RE_HI][HW-1:0], rw_q[REG_RE_LO]};
        im_center <= {rw_q[REG_IM_HI][HW-1:0], rw_q[REG_IM_LO]};
        max_iter  <= rw_q[REG_MAX_ITER][15:0];
        enable    <= rw_q[REG_CTRL][CTRL_EN];
      end else if (commit_wr) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = 32'h0;
    if (int'(rd_idx) < NUM_RW)                            rd_data = rw_nxt[rd_idx];
    else if (rd_idx == IDX_W'(NUM_REGS - OFS_STATUS))    rd_data = {31'h0, pending};
    else if (rd_idx == IDX_W'(NUM_REGS - OFS_FRAME_CNT)) rd_data = frame_cnt;
    else if (rd_idx == IDX_W'(NUM_REGS - OFS_VERSION))   rd_data = VERSION;
  end

endmodule
